// File: rtl/wb_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave Wishbone B4 classic arbiter.
// Ownership lasts a full cyc assertion; contention is round-robin; a watchdog errors hung transfers.
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [29:0] ibus_adr,
  input  logic [31:0] ibus_dat_w,
  input  logic [3:0]  ibus_sel,
  input  logic        ibus_cyc,
  input  logic        ibus_stb,
  input  logic        ibus_we,
  input  logic [2:0]  ibus_cti,
  input  logic [1:0]  ibus_bte,
  output logic [31:0] ibus_dat_r,
  output logic        ibus_ack,
  output logic        ibus_err,
  input  logic [29:0] dbus_adr,
  input  logic [31:0] dbus_dat_w,
  input  logic [3:0]  dbus_sel,
  input  logic        dbus_cyc,
  input  logic        dbus_stb,
  input  logic        dbus_we,
  input  logic [2:0]  dbus_cti,
  input  logic [1:0]  dbus_bte,
  output logic [31:0] dbus_dat_r,
  output logic        dbus_ack,
  output logic        dbus_err,
  output logic [29:0] mem_adr,
  output logic [31:0] mem_dat_w,
  output logic [3:0]  mem_sel,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [2:0]  mem_cti,
  output logic [1:0]  mem_bte,
  input  logic [31:0] mem_dat_r,
  input  logic        mem_ack,
  input  logic        mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} state_e;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } wb_req_t;

  state_e        state_q, state_d;
  logic          last_q, last_d;  // previous owner: 0 = ibus, 1 = dbus
  logic [CW-1:0] wd_q, wd_d;

  wb_req_t req_i, req_d, req_own;
  logic    own_i, own_d, own_cyc, own_stb, wd_fire, rsp_ack, rsp_err;

  always_comb begin
    req_i   = '{adr: ibus_adr, dat: ibus_dat_w, sel: ibus_sel, we: ibus_we,
                cti: ibus_cti, bte: ibus_bte};
    req_d   = '{adr: dbus_adr, dat: dbus_dat_w, sel: dbus_sel, we: dbus_we,
                cti: dbus_cti, bte: dbus_bte};
    own_i   = (state_q == OWN_I);
    own_d   = (state_q == OWN_D);
    req_own = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (own_i) begin
      req_own = req_i;
      own_cyc = ibus_cyc;
      own_stb = ibus_stb;
    end else if (own_d) begin
      req_own = req_d;
      own_cyc = dbus_cyc;
      own_stb = dbus_stb;
    end
    wd_fire = (TIMEOUT != 0) && own_cyc && own_stb && (wd_q == TO_V);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (ibus_cyc && dbus_cyc) state_d = last_q ? OWN_I : OWN_D;
        else if (ibus_cyc)        state_d = OWN_I;
        else if (dbus_cyc)        state_d = OWN_D;
      end
      OWN_I: if (!ibus_cyc) begin
        last_d  = 1'b0;
        state_d = dbus_cyc ? OWN_D : IDLE;
      end
      OWN_D: if (!dbus_cyc) begin
        last_d  = 1'b1;
        state_d = ibus_cyc ? OWN_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Counter only survives an unanswered strobe within an unchanged ownership.
    wd_d = '0;
    if ((TIMEOUT != 0) && (state_d == state_q) && own_cyc && own_stb &&
        !mem_ack && !mem_err && !wd_fire)
      wd_d = wd_q + CW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // A watchdog hit or a simultaneous ack+err both surface as err only.
  assign rsp_err = mem_err | wd_fire;
  assign rsp_ack = mem_ack & ~rsp_err;

  assign mem_adr   = req_own.adr;
  assign mem_dat_w = req_own.dat;
  assign mem_sel   = req_own.sel;
  assign mem_we    = req_own.we;
  assign mem_cti   = req_own.cti;
  assign mem_bte   = req_own.bte;
  assign mem_cyc   = own_cyc;
  assign mem_stb   = own_stb & ~wd_fire;

  assign ibus_ack   = own_i & rsp_ack;
  assign ibus_err   = own_i & rsp_err;
  assign dbus_ack   = own_d & rsp_ack;
  assign dbus_err   = own_d & rsp_err;
  assign ibus_dat_r = mem_dat_r;
  assign dbus_dat_r = mem_dat_r;

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master to one-slave Wishbone B4 classic arbiter that lets the Minerva core's instruction bus (ibus) and data bus (dbus) share one memory port. It grants ownership per bus cycle (held for the whole `cyc` assertion, including incrementing bursts). Simultaneous requests are resolved round-robin. A per-transfer watchdog converts a hung slave into a Wishbone error to the owning master.

## Interface
- `TIMEOUT`, default 255: cycles of unacknowledged `stb` before the watchdog fires. 0 disables the watchdog.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ibus_adr` in 30, `ibus_dat_w` in 32, `ibus_sel` in 4, `ibus_cyc` in 1, `ibus_stb` in 1, `ibus_we` in 1, `ibus_cti` in 3, `ibus_bte` in 2: master 0 request.
- `ibus_dat_r` out 32, `ibus_ack` out 1, `ibus_err` out 1: master 0 response.
- `dbus_*`: identical set for master 1.
- `mem_adr` out 30, `mem_dat_w` out 32, `mem_sel` out 4, `mem_cyc` out 1, `mem_stb` out 1, `mem_we` out 1, `mem_cti` out 3, `mem_bte` out 2: slave request.
- `mem_dat_r` in 32, `mem_ack` in 1, `mem_err` in 1: slave response.

## Operation
- State register takes three values: IDLE, OWN_I, OWN_D. A 1-bit `last` register records the previous owner. A watchdog counter is ceil(log2(TIMEOUT+1)) bits wide.
- Reset values:
  - State = IDLE, `last` = I, counter = 0.
  - `mem_cyc`, `mem_stb`, all master `ack`/`err` are 0.
  - Other `mem_*` outputs are 0.
- `ibus_dat_r` and `dbus_dat_r` always equal `mem_dat_r`.
- IDLE behaviour:
  - No request: stay in IDLE.
  - Only `ibus_cyc`: go to OWN_I. Only `dbus_cyc`: go to OWN_D.
  - Both: grant the master that is not `last`. After reset this is dbus.
- OWN_x behaviour:
  - All `mem_*` request outputs are combinationally muxed from master x.
  - `mem_ack`/`mem_err` are forwarded combinationally to x only. The other master sees ack=0, err=0.
  - In IDLE, `mem_cyc`=`mem_stb`=0 and the remaining `mem_*` outputs are 0.
- Release and handover:
  - When the owner drops `cyc`, `last` is set to that owner.
  - Next state is the other master's OWN state if its `cyc` is high, otherwise IDLE. There are no dead cycles on handover.
- Ownership never changes while the owner's `cyc` is high, regardless of `cti`.
- Watchdog, only when TIMEOUT≠0:
  - The counter increments each cycle in which the owner has `cyc&stb`=1 and `mem_ack|mem_err`=0.
  - It clears on any `mem_ack`/`mem_err`, on `stb`=0, and on any state change.
  - When it reaches TIMEOUT:
    - In that same cycle the owner sees `err`=1 and `ack`=0.
    - `mem_stb` is forced to 0 for that cycle.
    - The counter clears.
  - The owner decides whether to retry or drop `cyc`.
- If `mem_ack` and `mem_err` arrive together, the master gets `err`=1 and `ack`=0.
- Reset asserted mid-transfer: state returns to IDLE immediately and asynchronously, so `mem_cyc` drops in the same instant. Any pending transfer is abandoned without ack.

## Timing
- Grant latency: a request raised in cycle N while in IDLE produces `mem_cyc`/`mem_stb` in cycle N+1.
- A master that already owns the bus sees zero added latency. Slave `ack` at cycle M appears at the master in cycle M.
- Handover: owner drops `cyc` in cycle N and the waiting master drives `mem_*` in cycle N+1.
- Watchdog: `stb` held from cycle S with no ack produces `err` in cycle S+TIMEOUT.
- `resetn` deassertion is not required to be synchronised inside this block. The integrator supplies a synchronised release.

## Test plan
- Reset: with `resetn`=0 and both masters requesting, `mem_cyc`=0 and all acks/errs are 0. Release `resetn` → dbus owns in the first cycle after the release edge, `mem_adr`=`dbus_adr`.
- Single ibus read of adr 0x400, slave acks 2 cycles after grant → `mem_adr`=0x400 from cycle N+1. `ibus_ack`=1 and `ibus_dat_r`=`mem_dat_r` in cycle N+3. `dbus_ack` stays 0 throughout.
- Simultaneous requests repeated 4 times, each master holding `cyc` for 3 cycles → grant order is D, I, D, I with no idle cycle between owners.
- Burst lock: ibus issues a 4-beat `cti`=3'b010 burst while dbus requests from the burst's first beat → dbus is not granted until the cycle after `ibus_cyc` falls. All 4 beats reach the slave consecutively.
- Watchdog with TIMEOUT=4: dbus `stb` held with the slave silent → `dbus_err`=1 and `mem_stb`=0 in cycle S+4. Counter restarts, and a slave ack in cycle S+6 yields `dbus_ack`.
- Mid-transfer reset: pull `resetn` low while ibus owns with `stb` pending → `mem_cyc` falls without waiting for a clock edge, `ibus_ack` is never asserted, and the post-reset grant follows reset round-robin order.
